// File: rtl/guess_game_if.sv
// guess_game_if: game tick, mode, buttons in; target LEDs, result flags, level and scores out
interface guess_game_if #(
  parameter int N = 4,
  parameter int LW = 2,
  parameter int CNT_W = 4
);
  logic en;
  logic mode;
  logic [N-1:0] in;
  logic [N-1:0] y;
  logic win;
  logic lose;
  logic [LW-1:0] level;
  logic [CNT_W-1:0] win_cnt;
  logic [CNT_W-1:0] lose_cnt;
  modport master(output en, mode, in, input y, win, lose, level, win_cnt, lose_cnt);
  modport slave(input en, mode, in, output y, win, lose, level, win_cnt, lose_cnt);
endinterface

// File: rtl/guess_game.sv
// guess_game: walking one-hot target over N LEDs with level-dependent speed, saturating scores
module guess_game #(
  parameter int N = 4,
  parameter int MAX_LEVEL = 3,
  parameter int CNT_W = 4
) (
  input logic clk,
  input logic rst,
  guess_game_if.slave g
);
  localparam int LW = MAX_LEVEL > 0 ? $clog2(MAX_LEVEL + 1) : 1;
  localparam int PW = $clog2(N);
  typedef enum logic [1:0] {PLAY, WIN, LOSE} state_t;
  state_t st, st_n;
  logic [PW-1:0] pos, pos_n, adv_pos;
  logic dir, dir_n, adv_dir, top, bot;
  logic [LW-1:0] div, div_n, level, level_n;
  logic [CNT_W-1:0] wc, wc_n, lc, lc_n;
  logic [N-1:0] oh;
  assign g.level = level;
  assign g.win_cnt = wc;
  assign g.lose_cnt = lc;
  // adv_dir doubles as the "step down" flag: ping-pong moving down, or bouncing off the top
  always_comb begin
    oh = N'(1) << pos;
    top = pos == PW'(N - 1);
    bot = pos == '0;
    adv_dir = g.mode & (dir ? ~bot : top);
    adv_pos = adv_dir ? pos - PW'(1) : (!g.mode && top) ? '0 : pos + PW'(1);
    st_n = st;
    pos_n = pos;
    dir_n = dir;
    div_n = div;
    level_n = level;
    wc_n = wc;
    lc_n = lc;
    if (st == PLAY) begin
      if (g.in == oh) begin
        st_n = WIN;
        wc_n = &wc ? wc : wc + 1'b1;
        level_n = level == LW'(MAX_LEVEL) ? level : level + 1'b1;
      end else if (|g.in) begin
        st_n = LOSE;
        lc_n = &lc ? lc : lc + 1'b1;
        level_n = '0;
      end else if (div == LW'(MAX_LEVEL) - level) begin
        div_n = '0;
        pos_n = adv_pos;
        dir_n = adv_dir;
      end else begin
        div_n = div + 1'b1;
      end
    end else if (g.in == '0) begin
      st_n = PLAY;
      pos_n = '0;
      dir_n = 1'b0;
      div_n = '0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= PLAY;
      pos <= '0;
      dir <= 1'b0;
      div <= '0;
      level <= '0;
      wc <= '0;
      lc <= '0;
      g.y <= N'(1);
      g.win <= 1'b0;
      g.lose <= 1'b0;
    end else if (g.en) begin
      st <= st_n;
      pos <= pos_n;
      dir <= dir_n;
      div <= div_n;
      level <= level_n;
      wc <= wc_n;
      lc <= lc_n;
      g.y <= st_n == PLAY ? N'(1) << pos_n : '0;
      g.win <= st_n == WIN;
      g.lose <= st_n == LOSE;
    end
  end
endmodule

// File: tb/tb_guess_game.sv
// tb_guess_game: table vectors, corner sequences and random play against a behavioural model
module tb_guess_game;
  localparam int N = 4, ML = 3, CW = 4, LW = 2;
  localparam int SAT = (1 << CW) - 1;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  guess_game_if #(.N(N), .LW(LW), .CNT_W(CW)) g ();
  guess_game #(.N(N), .MAX_LEVEL(ML), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .g(g));
  typedef struct {
    logic en, mode;
    logic [3:0] in, y;
    logic win, lose;
    logic [1:0] lvl;
    logic [3:0] wc, lc;
  } vec_t;
  vec_t tbl[$];
  int total = 0, bad = 0;
  int ms, mp, md, mdiv, ml, mw, mlc;
  function automatic int my();
    return ms == 0 ? (1 << mp) : 0;
  endfunction
  task automatic mreset();
    ms = 0; mp = 0; md = 0; mdiv = 0; ml = 0; mw = 0; mlc = 0;
  endtask
  // ping-pong modelled as a signed step that reflects when it would leave 0..N-1
  task automatic mstep(input logic e, input logic m, input logic [N-1:0] i);
    int step;
    if (!e) return;
    if (ms == 0) begin
      if (int'(i) == my()) begin
        ms = 1; mw = mw < SAT ? mw + 1 : SAT; ml = ml < ML ? ml + 1 : ML;
      end else if (i != 0) begin
        ms = 2; mlc = mlc < SAT ? mlc + 1 : SAT; ml = 0;
      end else if (mdiv + 1 == ML + 1 - ml) begin
        mdiv = 0;
        if (!m) begin
          mp = (mp + 1) % N; md = 0;
        end else begin
          step = md ? -1 : 1;
          if (mp + step < 0 || mp + step > N - 1) begin md = !md; step = -step; end
          mp += step;
        end
      end else mdiv++;
    end else if (i == 0) begin
      ms = 0; mp = 0; md = 0; mdiv = 0;
    end
  endtask
  task automatic tick(input logic e, input logic m, input logic [N-1:0] i);
    g.en = e; g.mode = m; g.in = i;
    @(posedge clk);
    mstep(e, m, i);
    #1;
  endtask
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", n, a, e);
    end
  endtask
  task automatic chk_model(input string n);
    chk({n, " y"}, 32'(g.y), my());
    chk({n, " win"}, 32'(g.win), ms == 1);
    chk({n, " lose"}, 32'(g.lose), ms == 2);
    chk({n, " level"}, 32'(g.level), ml);
    chk({n, " win_cnt"}, 32'(g.win_cnt), mw);
    chk({n, " lose_cnt"}, 32'(g.lose_cnt), mlc);
  endtask
  function automatic void add(input logic e, m, input logic [3:0] i, y, input logic w, l,
                              input logic [1:0] lv, input logic [3:0] wc, lc);
    tbl.push_back('{e, m, i, y, w, l, lv, wc, lc});
  endfunction
  int pp[7] = '{2, 4, 8, 4, 2, 1, 2};
  initial begin
    for (int i = 1; i <= 24; i++) add(1, 0, 0, 4'(1 << ((i / 4) % 4)), 0, 0, 0, 0, 0);
    add(1, 0, 4'b0100, 0, 1, 0, 1, 1, 0);
    repeat (3) add(1, 0, 0, 1, 0, 0, 1, 1, 0);
    add(1, 0, 0, 2, 0, 0, 1, 1, 0);
    repeat (5) add(1, 0, 4'b0011, 0, 0, 1, 0, 1, 1);
    add(1, 0, 0, 1, 0, 0, 0, 1, 1);
    for (int i = 0; i < 10; i++) add(0, 1'(i), 4'b0001, 1, 0, 0, 0, 1, 1);
    g.en = 0; g.mode = 0; g.in = 0;
    mreset();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("reset y", 32'(g.y), 1);
    chk("reset win", 32'(g.win), 0);
    chk("reset lose", 32'(g.lose), 0);
    chk("reset level", 32'(g.level), 0);
    chk("reset counts", 32'({g.win_cnt, g.lose_cnt}), 0);
    foreach (tbl[k]) begin
      tick(tbl[k].en, tbl[k].mode, tbl[k].in);
      chk($sformatf("vec%0d y", k), 32'(g.y), 32'(tbl[k].y));
      chk($sformatf("vec%0d win", k), 32'(g.win), 32'(tbl[k].win));
      chk($sformatf("vec%0d lose", k), 32'(g.lose), 32'(tbl[k].lose));
      chk($sformatf("vec%0d level", k), 32'(g.level), 32'(tbl[k].lvl));
      chk($sformatf("vec%0d win_cnt", k), 32'(g.win_cnt), 32'(tbl[k].wc));
      chk($sformatf("vec%0d lose_cnt", k), 32'(g.lose_cnt), 32'(tbl[k].lc));
    end
    rst = 1; mreset();
    #2 rst = 0;
    repeat (3) begin tick(1, 0, 4'b0001); tick(1, 0, 0); end
    chk("pp level", 32'(g.level), 3);
    foreach (pp[k]) begin
      tick(1, 1, 0);
      chk($sformatf("pp%0d y", k), 32'(g.y), pp[k]);
    end
    repeat (16) begin tick(1, 0, 4'(my())); tick(1, 0, 0); end
    chk("sat win_cnt", 32'(g.win_cnt), 15);
    chk("sat level", 32'(g.level), 3);
    tick(1, 0, 4'b0010);
    chk("sat lose", 32'(g.lose), 1);
    chk("sat lose_cnt", 32'(g.lose_cnt), 1);
    chk("sat lose level", 32'(g.level), 0);
    chk("sat keep win_cnt", 32'(g.win_cnt), 15);
    tick(1, 0, 0);
    tick(1, 0, 4'b0001);
    chk("arst pre win", 32'(g.win), 1);
    #2 rst = 1;
    #1;
    chk("arst y", 32'(g.y), 1);
    chk("arst win", 32'(g.win), 0);
    chk("arst level", 32'(g.level), 0);
    chk("arst counts", 32'({g.win_cnt, g.lose_cnt}), 0);
    @(posedge clk);
    #1 rst = 0; mreset();
    for (int k = 0; k < 3000; k++) begin
      int r;
      logic [N-1:0] i;
      r = $urandom_range(9);
      i = r < 4 ? '0 : r < 7 ? 4'(my()) : 4'($urandom_range(15));
      tick($urandom_range(3) != 0, 1'($urandom_range(1)), i);
      chk_model($sformatf("rnd%0d", k));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
